// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding and word width for the load/store unit.
package cpu_pkg;
   localparam int WORD_W = 32;
   typedef logic [1:0] state_t;
   localparam state_t S_IDLE  = 2'd0;
   localparam state_t S_ISSUE = 2'd1;
   localparam state_t S_WAIT  = 2'd2;
   localparam state_t S_DONE  = 2'd3;
endpackage

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: load/store unit between the core and a fixed-latency word SRAM.
// One request is in flight at a time; the core is held with stall until DONE.
module dmem_ctrl
   import cpu_pkg::*;
#(
   parameter int MEM_LAT = 2,
   parameter int ADDR_W  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              misalign,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);
   localparam int CNT_W = $clog2(MEM_LAT + 1);

   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we, r_mis;
   logic [ADDR_W-1:0]   r_addr;
   logic [WORD_W-1:0]   r_wdata, r_rdata;
   logic                w_mis, w_cap, w_unused;

   assign w_mis    = req_addr[1:0] != 2'b00;
   assign w_unused = ^req_addr[31:ADDR_W+2];
   // A single-cycle SRAM delivers during ISSUE; otherwise on the last WAIT cycle.
   assign w_cap    = (r_state == S_ISSUE && !r_we && MEM_LAT == 1) ||
                     (r_state == S_WAIT && r_cnt == CNT_W'(1));

   always_ff @(posedge clk)
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;

   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = !req_valid ? S_IDLE : w_mis ? S_DONE : S_ISSUE;
         S_ISSUE: w_next = (r_we || MEM_LAT == 1) ? S_DONE : S_WAIT;
         S_WAIT:  w_next = (r_cnt == CNT_W'(1)) ? S_DONE : S_WAIT;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      stall    = (r_state == S_IDLE) ? req_valid : (r_state != S_DONE);
      mem_en   = r_state == S_ISSUE;
      mem_we   = (r_state == S_ISSUE) && r_we;
      misalign = (r_state == S_DONE) && r_mis;
   end

   always_ff @(posedge clk)
      if (reset) begin
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_mis   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (r_state == S_IDLE && req_valid) begin
            r_addr  <= req_addr[ADDR_W+1:2];
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_mis   <= w_mis;
            if (w_mis && !req_we) r_rdata <= '0;
         end
         if (r_state == S_ISSUE && !r_we) r_cnt <= CNT_W'(MEM_LAT - 1);
         else if (r_state == S_WAIT)      r_cnt <= r_cnt - CNT_W'(1);
         if (w_cap) r_rdata <= mem_rdata;
      end

   assign rdata     = r_rdata;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: three controllers (MEM_LAT 1/2/4) each on a behavioural SRAM,
// checked with a vector table, corner sequences and a random run against a word-level model.
module tb_dmem_ctrl;
   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        req_valid, req_we, stall, misalign, mem_en, mem_we;
   logic [31:0]       req_addr [3];
   logic [31:0]       req_wdata [3];
   logic [31:0]       rdata [3];
   logic [31:0]       mem_wdata [3];
   logic [31:0]       mem_rdata [3];
   logic [5:0]        mem_addr [3];

   int                checks = 0, failures = 0;
   int                lat [3] = '{1, 2, 4};
   logic [31:0]       ref_mem [3][64];
   logic [31:0]       ref_rd [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
      logic [31:0] mem [64] = '{default: 32'h0};
      logic [31:0] pipe [4];
      dmem_ctrl #(.MEM_LAT(L), .ADDR_W(6)) u_dut (
         .clk(clk), .reset(reset),
         .req_valid(req_valid[g]), .req_we(req_we[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
         .stall(stall[g]), .rdata(rdata[g]), .misalign(misalign[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
      );
      always @(posedge clk) begin
         if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
         pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hDEAD_BEEF;
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      if (L == 1) begin : g_comb
         assign mem_rdata[g] = (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hDEAD_BEEF;
      end else begin : g_pipe
         assign mem_rdata[g] = pipe[L-2];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int e_stall, output logic [31:0] e_rd, output logic e_mis);
      int w;
      w = (addr / 4) % 64;
      e_mis = addr[1:0] != 2'b00;
      if (e_mis) begin
         e_stall = 1;
         if (!we) ref_rd[k] = 32'h0;
      end else if (we) begin
         e_stall = 2;
         ref_mem[k][w] = wdata;
      end else begin
         e_stall = lat[k] + 1;
         ref_rd[k] = ref_mem[k][w];
      end
      e_rd = ref_rd[k];
   endtask

   task automatic op(input string nm, input int k, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic keep, input int e_stall,
                     input logic [31:0] e_rd, input logic e_mis);
      int ns = 0, nen = 0, nmis = 0;
      logic done = 1'b0, we_seen = 1'b0;
      logic [5:0] a_seen = '0;
      logic [31:0] wd_seen = '0;
      req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (mem_en[k]) begin
            nen++; a_seen = mem_addr[k]; we_seen = mem_we[k]; wd_seen = mem_wdata[k];
         end
         if (misalign[k]) nmis++;
         if (!stall[k]) begin
            done = 1'b1;
            chk($sformatf("%s_rdata", nm), rdata[k], e_rd);
         end else ns++;
         @(posedge clk); #1;
      end
      if (!keep) req_valid[k] = 1'b0;
      chk($sformatf("%s_release", nm), done, 1'b1);
      chk($sformatf("%s_stall", nm), ns, e_stall);
      chk($sformatf("%s_mem_en", nm), nen, e_mis ? 0 : 1);
      chk($sformatf("%s_misalign", nm), nmis, e_mis ? 1 : 0);
      if (!e_mis) begin
         chk($sformatf("%s_mem_addr", nm), a_seen, (addr >> 2) & 32'h3F);
         chk($sformatf("%s_mem_we", nm), we_seen, we);
         if (we) chk($sformatf("%s_mem_wdata", nm), wd_seen, wdata);
      end
   endtask

   task automatic idle(input int n, input int k);
      int en = 0, st = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (mem_en[k]) en++;
         if (stall[k]) st++;
         @(posedge clk); #1;
      end
      chk("idle_mem_en", en, 0);
      chk("idle_stall", st, 0);
   endtask

   typedef struct {
      int          k;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        keep;
      int          e_stall;
      logic [31:0] e_rd;
      logic        e_mis;
   } vec_t;

   vec_t tbl [15];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          es, wr, k;
      logic        em, we;
      logic [31:0] er, a, wd;
      tbl[0]  = '{1, 1'b1, 32'h14,  32'h0000_00A5, 1'b0, 2, 32'h0,         1'b0};
      tbl[1]  = '{1, 1'b0, 32'h14,  32'h0,         1'b0, 3, 32'h0000_00A5, 1'b0};
      tbl[2]  = '{1, 1'b0, 32'h16,  32'h0,         1'b0, 1, 32'h0,         1'b1};
      tbl[3]  = '{1, 1'b1, 32'h100, 32'h1234_5678, 1'b0, 2, 32'h0,         1'b0};
      tbl[4]  = '{1, 1'b0, 32'h0,   32'h0,         1'b0, 3, 32'h1234_5678, 1'b0};
      tbl[5]  = '{1, 1'b1, 32'h8,   32'hCAFE_F00D, 1'b0, 2, 32'h1234_5678, 1'b0};
      tbl[6]  = '{1, 1'b0, 32'h14,  32'h0,         1'b1, 3, 32'h0000_00A5, 1'b0};
      tbl[7]  = '{1, 1'b0, 32'h8,   32'h0,         1'b0, 3, 32'hCAFE_F00D, 1'b0};
      tbl[8]  = '{1, 1'b1, 32'h13,  32'hFFFF_FFFF, 1'b0, 1, 32'hCAFE_F00D, 1'b1};
      tbl[9]  = '{1, 1'b0, 32'h10,  32'h0,         1'b0, 3, 32'h0,         1'b0};
      tbl[10] = '{0, 1'b1, 32'h20,  32'h1111_1111, 1'b0, 2, 32'h0,         1'b0};
      tbl[11] = '{0, 1'b0, 32'h20,  32'h0,         1'b0, 2, 32'h1111_1111, 1'b0};
      tbl[12] = '{2, 1'b1, 32'h3C,  32'h4444_4444, 1'b0, 2, 32'h0,         1'b0};
      tbl[13] = '{2, 1'b0, 32'h3C,  32'h0,         1'b0, 5, 32'h4444_4444, 1'b0};
      tbl[14] = '{2, 1'b0, 32'h20,  32'h0,         1'b0, 5, 32'h0,         1'b0};
      for (int i = 0; i < 3; i++) begin
         ref_rd[i] = 32'h0;
         for (int j = 0; j < 64; j++) ref_mem[i][j] = 32'h0;
         req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
      end
      reset = 1'b1; req_valid = '0; req_we = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_stall", stall, 3'b000);
      chk("rst_mem_en", mem_en, 3'b000);
      chk("rst_misalign", misalign, 3'b000);
      chk("rst_rdata", rdata[1], 32'h0);
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) begin
         model(tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wdata, es, er, em);
         op($sformatf("vec%0d", i), tbl[i].k, tbl[i].we, tbl[i].addr, tbl[i].wdata,
            tbl[i].keep, tbl[i].e_stall, tbl[i].e_rd, tbl[i].e_mis);
         if (i == 7) idle(3, 1);
      end

      // Reset in the middle of a load must abandon it cleanly.
      model(1, 1'b0, 32'h0, 32'h0, es, er, em);
      op("pre_rst", 1, 1'b0, 32'h0, 32'h0, 1'b0, es, er, em);
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h14;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; req_valid[1] = 1'b0;
      wr = 0;
      repeat (2) begin
         @(negedge clk);
         if (mem_en[1] && mem_we[1]) wr++;
         @(posedge clk);
      end
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_stall", stall[1], 1'b0);
      chk("midrst_mem_en", mem_en[1], 1'b0);
      chk("midrst_rdata", rdata[1], 32'h0);
      chk("midrst_writes", wr, 0);
      for (int i = 0; i < 3; i++) ref_rd[i] = 32'h0;
      @(posedge clk); #1;

      for (int i = 0; i < 80; i++) begin
         k  = $urandom_range(0, 2);
         we = 1'($urandom_range(0, 1));
         a  = $urandom_range(0, 1023);
         wd = $urandom;
         if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
         model(k, we, a, wd, es, er, em);
         op($sformatf("rnd%0d", i), k, we, a, wd, 1'b0, es, er, em);
         if ($urandom_range(0, 3) == 0) idle(2, k);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
